nios_cpu_ocimem_ctrl: RTL
=========================

Name: nios_cpu_ocimem_ctrl

Overview:
Debug on-chip memory controller sitting directly downstream of the Nios debug-slave sysclk stage. It consumes the single-cycle take_action_ocimem_a/b and take_no_action_ocimem_a strobes plus the 38-bit jdo word. It executes JTAG monitor reads and writes against an internal single-port debug RAM that is shared with the CPU's debug Avalon slave port. It returns MonDReg, monitor_ready and monitor_error to the debug-slave TCK side.

Parameters:
ADDR_W, 8, word-address width of debug RAM and MonAReg.
DEPTH, 256, implemented words (DEPTH <= 2**ADDR_W); addresses >= DEPTH are out of range.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
jdo  in  38  JTAG data word from sysclk stage.
take_action_ocimem_a  in  1  load-address command strobe.
take_no_action_ocimem_a  in  1  read-next (auto-increment) strobe.
take_action_ocimem_b  in  1  write-data strobe.
cpu_address  in  ADDR_W  CPU word address.
cpu_read  in  1  CPU read request.
cpu_write  in  1  CPU write request.
cpu_writedata  in  32  CPU write data.
cpu_byteenable  in  4  CPU byte lanes.
cpu_readdata  out  32  CPU read data.
cpu_waitrequest  out  1  CPU stall.
MonDReg  out  32  monitor data register.
MonAReg  out  ADDR_W  monitor address register.
monitor_ready  out  1  MonDReg holds the result of the last JTAG read.
monitor_error  out  1  sticky JTAG error flag.

Behaviour:
- Reset (sync, high): MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, cpu_readdata=0, state=IDLE, jtag_pend=0. RAM contents are not reset. Reset mid-access aborts the access; no RAM write occurs in the reset cycle.
- RAM: single port, 32-bit, byte-writable, 1-cycle registered read. At most one access per cycle.
- JTAG command decode:
  - ocimem_a: MonAReg<=jdo[ADDR_W+1:2]; monitor_error<=0. If jdo[34]=1, queue a JTAG read at the new address.
  - no_action_ocimem_a: MonAReg<=MonAReg+1 (mod 2**ADDR_W), then queue a read at the incremented address.
  - ocimem_b: MonDReg<=jdo[34:3]; queue a full-word write to RAM[MonAReg]. MonAReg increments after the write completes.
  - Any strobe clears monitor_ready in the following cycle.
- Pending/overrun: a strobe that arrives while the FSM is not IDLE is latched into jtag_pend (one deep). A second strobe while jtag_pend=1 is dropped and sets monitor_error.
- Out-of-range: a JTAG access with MonAReg>=DEPTH touches no RAM; it sets monitor_error, and a read returns MonDReg=0 with monitor_ready=1.
- FSM states: IDLE, J_RD, J_CAP, J_WR, C_RD, C_DONE.
  - IDLE: a JTAG command (new strobe or jtag_pend) has priority over CPU. Read->J_RD; write->J_WR. Else cpu_read->C_RD. Else cpu_write is performed in this same cycle and stays IDLE.
  - J_RD: RAM address is driven; ->J_CAP.
  - J_CAP: MonDReg<=RAM q; monitor_ready<=1; ->IDLE.
  - J_WR: RAM write; MonAReg++; ->IDLE.
  - C_RD: ->C_DONE.
  - C_DONE: cpu_readdata<=q; ->IDLE.
- JTAG read latency: strobe at cycle N -> MonDReg valid, monitor_ready=1 at N+3 (registered outputs).
- cpu_waitrequest (combinational):
  - =1 when (cpu_read|cpu_write) and not accepted this cycle. A write is accepted only in IDLE with no JTAG command.
  - =1 for a read until the C_DONE cycle, where it drops and cpu_readdata is valid on the next edge. Readdata is presented registered; waitrequest=0 coincides with valid readdata.
  - CPU requests must be held while waitrequest=1.
- Simultaneous JTAG strobe and cpu_write in IDLE: the JTAG access goes first; the CPU write stalls at least 1 cycle.
- The CPU never writes MonDReg/MonAReg.

Test Plan:
- Reset, then ocimem_a with jdo[9:2]=0x05, jdo[34]=1, RAM[5]=0xDEADBEEF preloaded via CPU -> MonDReg=0xDEADBEEF, monitor_ready=1 three cycles after the strobe, MonAReg=5.
- ocimem_a addr=0xFF (DEPTH=256) then no_action_ocimem_a -> MonAReg wraps to 0x00, MonDReg=RAM[0].
- ocimem_b with jdo[34:3]=0x12345678 at MonAReg=3, then CPU read addr 3 -> cpu_readdata=0x12345678; MonAReg=4.
- cpu_write addr 7 and ocimem_b strobe in the same IDLE cycle -> JTAG write completes first, cpu_waitrequest=1 for >=1 cycle, both writes land correctly.
- During a CPU read (C_RD), two JTAG strobes in consecutive cycles -> the first is served after C_DONE, the second is dropped, monitor_error=1; the next ocimem_a clears it.
- DEPTH=200, ocimem_a addr=210, jdo[34]=1 -> monitor_error=1, MonDReg=0, monitor_ready=1, RAM unchanged.

Source files
------------

// File: rtl/nios_cpu_ocimem_ctrl.sv
// Nios debug OCI memory controller: JTAG monitor reads/writes
// and the CPU debug slave share one single-port debug RAM.
module nios_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_J_RD, S_J_CAP, S_J_WR, S_C_RD, S_C_DONE
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_A, K_N, K_B} kind_t;

  localparam int            LIM_I = DEPTH;
  localparam logic [ADDR_W:0] LIM = LIM_I[ADDR_W:0];

  state_t            r_state;
  logic              r_pend_v;
  kind_t             r_pend_k;
  logic [34:2]       r_pend_jdo;
  logic [31:0]       r_mdr;
  logic [ADDR_W-1:0] r_mar;
  logic              r_rdy;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_q;
  logic [31:0]       r_mem [DEPTH];

  kind_t             w_new_k;
  kind_t             w_cmd_k;
  logic [34:2]       w_cmd_jdo;
  logic              w_idle;
  logic              w_strobe;
  logic              w_jcmd;
  logic              w_crd_go;
  logic              w_cwr_go;
  logic              w_mar_ok;
  logic              w_cpu_ok;
  logic              w_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wd;
  logic [3:0]        w_be;
  logic              w_unused;

  assign w_unused = ^{jdo[37:35], jdo[1:0]};

  assign w_strobe = take_action_ocimem_a
                  | take_no_action_ocimem_a
                  | take_action_ocimem_b;

  // Strobes are one-hot from the sysclk stage
  always_comb begin
    w_new_k = K_NONE;
    unique case (1'b1)
      take_action_ocimem_a:    w_new_k = K_A;
      take_no_action_ocimem_a: w_new_k = K_N;
      take_action_ocimem_b:    w_new_k = K_B;
      default:                 w_new_k = K_NONE;
    endcase
  end

  assign w_cmd_k   = r_pend_v ? r_pend_k : w_new_k;
  assign w_cmd_jdo = r_pend_v ? r_pend_jdo : jdo[34:2];
  assign w_idle    = (r_state == S_IDLE);
  assign w_jcmd    = w_idle && (w_cmd_k != K_NONE);
  assign w_crd_go  = w_idle && !w_jcmd && cpu_read;
  assign w_cwr_go  = w_idle && !w_jcmd && !cpu_read
                   && cpu_write;
  assign w_mar_ok  = {1'b0, r_mar} < LIM;
  assign w_cpu_ok  = {1'b0, cpu_address} < LIM;

  assign cpu_waitrequest = cpu_read
                         ? (r_state != S_C_DONE)
                         : (cpu_write && !w_cwr_go);

  always_comb begin
    w_re   = 1'b0;
    w_we   = 1'b0;
    w_addr = cpu_address;
    w_wd   = cpu_writedata;
    w_be   = cpu_byteenable;
    if (r_state == S_J_RD) begin
      w_re   = w_mar_ok;
      w_addr = r_mar;
    end else if (r_state == S_J_WR) begin
      w_we   = w_mar_ok;
      w_addr = r_mar;
      w_wd   = r_mdr;
      w_be   = 4'hF;
    end else if (w_crd_go) begin
      w_re = w_cpu_ok;
    end else if (w_cwr_go) begin
      w_we = w_cpu_ok;
    end
    if (reset) begin
      w_re = 1'b0;
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
    if (w_re) r_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pend_v   <= 1'b0;
      r_pend_k   <= K_NONE;
      r_pend_jdo <= '0;
      r_mdr      <= '0;
      r_mar      <= '0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_jcmd) begin
            unique case (w_cmd_k)
              K_A: begin
                r_mar <= w_cmd_jdo[ADDR_W+1:2];
                r_err <= 1'b0;
                if (w_cmd_jdo[34]) r_state <= S_J_RD;
              end
              K_N: begin
                r_mar   <= r_mar + ADDR_W'(1);
                r_state <= S_J_RD;
              end
              K_B: begin
                r_mdr   <= w_cmd_jdo[34:3];
                r_state <= S_J_WR;
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (cpu_read) begin
            r_state <= S_C_RD;
          end
        end
        S_J_RD: r_state <= S_J_CAP;
        S_J_CAP: begin
          r_mdr   <= w_mar_ok ? r_q : '0;
          r_rdy   <= 1'b1;
          if (!w_mar_ok) r_err <= 1'b1;
          r_state <= S_IDLE;
        end
        S_J_WR: begin
          r_mar   <= r_mar + ADDR_W'(1);
          if (!w_mar_ok) r_err <= 1'b1;
          r_state <= S_IDLE;
        end
        // RAM was read on acceptance, so data is ready before C_DONE
        S_C_RD: begin
          r_rdata <= w_cpu_ok ? r_q : '0;
          r_state <= S_C_DONE;
        end
        S_C_DONE: begin
          r_rdata <= w_cpu_ok ? r_q : '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_idle && r_pend_v) r_pend_v <= 1'b0;
      if (w_strobe) begin
        r_rdy <= 1'b0;
        if (!w_idle && r_pend_v) begin
          r_err <= 1'b1;
        end else if (!w_idle || r_pend_v) begin
          r_pend_v   <= 1'b1;
          r_pend_k   <= w_new_k;
          r_pend_jdo <= jdo[34:2];
        end
      end
    end
  end

  assign cpu_readdata  = r_rdata;
  assign MonDReg       = r_mdr;
  assign MonAReg       = r_mar;
  assign monitor_ready = r_rdy;
  assign monitor_error = r_err;

endmodule
